// File: rtl/dram_responder_pkg.sv
// Shared definitions for the DRAM request responder: lane count,
// read/write encoding of dram_rdwr, the per-lane state encoding and
// a range-check helper used by the top level.
package dram_responder_pkg;

    localparam int DRAM_LANES = 8;

    // dram_rdwr encoding, shared by all lanes of one request cycle
    localparam logic DRAM_RD = 1'b1;
    localparam logic DRAM_WR = 1'b0;

    // Width of the per-lane latency counter (LATENCY is 1..15)
    localparam int CNT_W = 4;

    typedef enum logic [1:0] {
        LN_IDLE = 2'd0,
        LN_BUSY = 2'd1,
        LN_RESP = 2'd2
    } dram_lane_t;

    // Full 64-bit compare against the backing array size
    function automatic logic addr_in_range(input logic [63:0] addr, input int unsigned depth);
        return addr < 64'(depth);
    endfunction

endpackage

// File: rtl/dram_responder_lane.sv
// One responder lane: holds the response byte captured at accept time,
// counts down the programmed latency and emits a single-cycle valid.
// The current state is exported so checkers can observe the FSM directly.
module dram_lane
    import dram_responder_pkg::*;
#(
    parameter int LATENCY = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       accept,     // request taken this cycle (top guarantees lane idle)
    input  logic [7:0] resp_byte,  // byte to return: read data, or 8'h00 for writes/out-of-range
    output logic       busy,
    output logic       valid,
    output logic [7:0] data,
    output dram_lane_t state
);

    // The accept edge itself counts as the first latency cycle and the
    // RESP cycle as the last, so BUSY lasts LATENCY-1 cycles and the
    // counter is loaded with LATENCY-2. LATENCY=1 skips BUSY entirely.
    localparam logic [CNT_W-1:0] CNT_LOAD = (LATENCY >= 2) ? CNT_W'(LATENCY - 2) : '0;

    dram_lane_t       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [7:0]       hold_q, hold_d;
    logic [7:0]       data_q, data_d;

    // Next-state, counter and data-hold logic
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        hold_d  = hold_q;
        data_d  = data_q;
        unique case (state_q)
            LN_IDLE: begin
                if (accept) begin
                    hold_d = resp_byte;
                    if (LATENCY == 1) begin
                        state_d = LN_RESP;
                        data_d  = resp_byte;
                    end else begin
                        state_d = LN_BUSY;
                        cnt_d   = CNT_LOAD;
                    end
                end
            end
            LN_BUSY: begin
                if (cnt_q == '0) begin
                    state_d = LN_RESP;
                    data_d  = hold_q;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            LN_RESP: begin
                // New strobes in this cycle are refused by the top (busy=1)
                state_d = LN_IDLE;
            end
            default: begin
                state_d = LN_IDLE;
            end
        endcase
    end

    // Lane state registers; reset abandons any outstanding request
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= LN_IDLE;
            cnt_q   <= '0;
            hold_q  <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            hold_q  <= hold_d;
            data_q  <= data_d;
        end
    end

    assign busy  = (state_q != LN_IDLE);
    assign valid = (state_q == LN_RESP);
    assign data  = data_q;
    assign state = state_q;

endmodule

// File: rtl/dram_responder.sv
// Responder for the 8-lane byte-wide DRAM request interface used by fetch.
// Owns the byte-addressed backing array, the host preload port, write
// arbitration between lanes and preload, range checks and sticky errors.
// Each lane's timing lives in dram_lane. The array is a behavioural
// simulation model (many read/write ports) and is not meant for synthesis.
//
// Handshake: a lane takes a request when dram_en[i]=1 and lane_busy[i]=0;
// exactly LATENCY cycles later (counting the accept edge as the first)
// dram_valid[i] is high for one cycle with dram_data[i]. A strobe on a busy
// lane is dropped and flagged; there is no backpressure signal.
module dram_responder
    import dram_responder_pkg::*;
#(
    parameter int DEPTH   = 4096,
    parameter int LATENCY = 4
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic [DRAM_LANES-1:0]           dram_en,
    input  logic                            dram_rdwr,
    input  logic [DRAM_LANES-1:0][63:0]     dram_addr,
    input  logic [DRAM_LANES-1:0][7:0]      dram_wdata,
    output logic [DRAM_LANES-1:0]           dram_valid,
    output logic [DRAM_LANES-1:0][7:0]      dram_data,
    input  logic                            load_en,
    input  logic [63:0]                     load_addr,
    input  logic [7:0]                      load_data,
    output logic [DRAM_LANES-1:0]           lane_busy,
    output logic                            err_oob,
    output logic                            err_overlap,
    output dram_lane_t [DRAM_LANES-1:0]     lane_state
);

    localparam int AW = $clog2(DEPTH);

    logic [7:0] mem [DEPTH];

    logic [DRAM_LANES-1:0]      accept;
    logic [DRAM_LANES-1:0]      lane_oob;
    logic [DRAM_LANES-1:0]      lane_wr;
    logic [DRAM_LANES-1:0][7:0] resp_byte;
    logic                       load_oob;
    logic                       load_wr;

    logic err_oob_q, err_oob_d;
    logic err_overlap_q, err_overlap_d;

    // Per-lane accept, range check, write enable and response byte
    always_comb begin
        for (int i = 0; i < DRAM_LANES; i++) begin
            accept[i]    = dram_en[i] & ~lane_busy[i];
            lane_oob[i]  = ~addr_in_range(dram_addr[i], DEPTH);
            lane_wr[i]   = accept[i] & (dram_rdwr == DRAM_WR) & ~lane_oob[i];
            resp_byte[i] = 8'h00;
            // Array read sees the contents before this edge's writes
            if ((dram_rdwr == DRAM_RD) && !lane_oob[i]) begin
                resp_byte[i] = mem[dram_addr[i][AW-1:0]];
            end
        end
        load_oob = ~addr_in_range(load_addr, DEPTH);
        load_wr  = load_en & ~load_oob;
    end

    // Backing array: preload applied first, then lanes in ascending order,
    // so the highest lane wins and any lane write overrides a preload
    always_ff @(posedge clk) begin
        if (load_wr) begin
            mem[load_addr[AW-1:0]] <= load_data;
        end
        for (int i = 0; i < DRAM_LANES; i++) begin
            if (lane_wr[i]) begin
                mem[dram_addr[i][AW-1:0]] <= dram_wdata[i];
            end
        end
    end

    // Sticky error flag accumulation
    always_comb begin
        err_oob_d     = err_oob_q | (|(accept & lane_oob)) | (load_en & load_oob);
        err_overlap_d = err_overlap_q | (|(dram_en & lane_busy));
    end

    // Sticky error registers, cleared only by reset
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            err_oob_q     <= 1'b0;
            err_overlap_q <= 1'b0;
        end else begin
            err_oob_q     <= err_oob_d;
            err_overlap_q <= err_overlap_d;
        end
    end

    assign err_oob     = err_oob_q;
    assign err_overlap = err_overlap_q;

    for (genvar g = 0; g < DRAM_LANES; g++) begin : g_lane
        dram_lane #(
            .LATENCY (LATENCY)
        ) u_lane (
            .clk       (clk),
            .rst_n     (reset),
            .accept    (accept[g]),
            .resp_byte (resp_byte[g]),
            .busy      (lane_busy[g]),
            .valid     (dram_valid[g]),
            .data      (dram_data[g]),
            .state     (lane_state[g])
        );
    end

endmodule

// File: tb/tb_dram_responder.sv
// Bench for dram_responder. Three instances (LATENCY 4, 1, 15) share the
// same stimulus; a byte-array model of memory plus the latency rule
// predicts every completion.
module tb_dram_responder;
    import dram_responder_pkg::*;

    localparam int DEPTH = 4096;
    localparam int NDUT  = 3;
    localparam int LMAX  = 15;

    logic                 clk = 1'b0;
    logic                 reset;
    logic [7:0]           dram_en;
    logic                 dram_rdwr;
    logic [7:0][63:0]     dram_addr;
    logic [7:0][7:0]      dram_wdata;
    logic                 load_en;
    logic [63:0]          load_addr;
    logic [7:0]           load_data;

    logic [7:0]           dv [NDUT];
    logic [7:0][7:0]      dd [NDUT];
    logic [7:0]           lb [NDUT];
    logic                 eo [NDUT];
    logic                 ev [NDUT];
    dram_lane_t [7:0]     ls [NDUT];

    logic [7:0] exp_mem [DEPTH];
    logic       exp_oob;
    int         cyc;
    int         errors;
    int         checks;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    dram_responder #(.DEPTH(DEPTH), .LATENCY(4)) u_dut_l4 (
        .clk(clk), .reset(reset), .dram_en(dram_en), .dram_rdwr(dram_rdwr),
        .dram_addr(dram_addr), .dram_wdata(dram_wdata), .dram_valid(dv[0]), .dram_data(dd[0]),
        .load_en(load_en), .load_addr(load_addr), .load_data(load_data), .lane_busy(lb[0]),
        .err_oob(eo[0]), .err_overlap(ev[0]), .lane_state(ls[0])
    );

    dram_responder #(.DEPTH(DEPTH), .LATENCY(1)) u_dut_l1 (
        .clk(clk), .reset(reset), .dram_en(dram_en), .dram_rdwr(dram_rdwr),
        .dram_addr(dram_addr), .dram_wdata(dram_wdata), .dram_valid(dv[1]), .dram_data(dd[1]),
        .load_en(load_en), .load_addr(load_addr), .load_data(load_data), .lane_busy(lb[1]),
        .err_oob(eo[1]), .err_overlap(ev[1]), .lane_state(ls[1])
    );

    dram_responder #(.DEPTH(DEPTH), .LATENCY(15)) u_dut_l15 (
        .clk(clk), .reset(reset), .dram_en(dram_en), .dram_rdwr(dram_rdwr),
        .dram_addr(dram_addr), .dram_wdata(dram_wdata), .dram_valid(dv[2]), .dram_data(dd[2]),
        .load_en(load_en), .load_addr(load_addr), .load_data(load_data), .lane_busy(lb[2]),
        .err_oob(eo[2]), .err_overlap(ev[2]), .lane_state(ls[2])
    );

    function automatic int lat_of(input int d);
        case (d)
            0:       return 4;
            1:       return 1;
            default: return 15;
        endcase
    endfunction

    // Host preload of one byte; out-of-range loads are dropped and flagged
    task automatic load_byte(input logic [63:0] a, input logic [7:0] v);
        @(negedge clk);
        load_en = 1'b1; load_addr = a; load_data = v;
        @(posedge clk); #1;
        load_en = 1'b0;
        if (a < 64'(DEPTH)) exp_mem[a[11:0]] = v;
        else exp_oob = 1'b1;
    endtask

    // One request cycle (optionally with a concurrent preload), then watch
    // every instance until the slowest one is idle again
    task automatic do_burst(input string tag, input logic [7:0] en, input logic rdwr,
                            input logic [7:0][63:0] addr, input logic [7:0][7:0] wdata,
                            input logic ld, input logic [63:0] ld_addr, input logic [7:0] ld_data,
                            output logic [7:0][7:0] got);
        logic [7:0][7:0] exp_d;
        logic [7:0]      exp_v;
        int              a;
        got = '0;
        for (int i = 0; i < 8; i++) begin
            exp_d[i] = 8'h00;
            if (en[i] && rdwr && addr[i] < 64'(DEPTH)) exp_d[i] = exp_mem[addr[i][11:0]];
            if (en[i] && addr[i] >= 64'(DEPTH)) exp_oob = 1'b1;
        end
        if (ld) begin
            if (ld_addr < 64'(DEPTH)) exp_mem[ld_addr[11:0]] = ld_data;
            else exp_oob = 1'b1;
        end
        for (int i = 0; i < 8; i++) begin
            if (en[i] && !rdwr && addr[i] < 64'(DEPTH)) exp_mem[addr[i][11:0]] = wdata[i];
        end
        @(negedge clk);
        dram_en = en; dram_rdwr = rdwr; dram_addr = addr; dram_wdata = wdata;
        load_en = ld; load_addr = ld_addr; load_data = ld_data;
        @(posedge clk); #1;
        a = cyc;
        dram_en = '0; load_en = 1'b0;
        for (int k = 0; k <= LMAX; k++) begin
            @(negedge clk);
            for (int d = 0; d < NDUT; d++) begin
                if (k == 0) begin
                    checks++;
                    if (lb[d] !== en) begin
                        errors++;
                        $display("FAIL %s busy dut%0d: got %h expected %h", tag, d, lb[d], en);
                    end
                end
                exp_v = (cyc == a + lat_of(d) - 1) ? en : 8'h00;
                checks++;
                if (dv[d] !== exp_v) begin
                    errors++;
                    $display("FAIL %s valid dut%0d cyc+%0d: got %h expected %h", tag, d, cyc - a, dv[d], exp_v);
                end
                for (int i = 0; i < 8; i++) begin
                    if (exp_v[i]) begin
                        checks++;
                        if (dd[d][i] !== exp_d[i]) begin
                            errors++;
                            $display("FAIL %s data dut%0d lane%0d: got %h expected %h", tag, d, i, dd[d][i], exp_d[i]);
                        end
                        if (d == 0) got[i] = dd[d][i];
                    end
                end
            end
        end
        for (int d = 0; d < NDUT; d++) begin
            checks++;
            if (lb[d] !== 8'h00) begin
                errors++;
                $display("FAIL %s idle dut%0d: got %h expected 00", tag, d, lb[d]);
            end
            checks++;
            if (eo[d] !== exp_oob) begin
                errors++;
                $display("FAIL %s err_oob dut%0d: got %b expected %b", tag, d, eo[d], exp_oob);
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        dram_en = '0; dram_rdwr = 1'b1; dram_addr = '0; dram_wdata = '0;
        load_en = 1'b0; load_addr = '0; load_data = '0;
        exp_oob = 1'b0;
        repeat (3) @(negedge clk);
        for (int d = 0; d < NDUT; d++) begin
            checks++;
            if (dv[d] !== 8'h00 || dd[d] !== 64'h0 || lb[d] !== 8'h00) begin
                errors++;
                $display("FAIL reset outputs dut%0d: got valid=%h data=%h busy=%h expected all zero", d, dv[d], dd[d], lb[d]);
            end
            checks++;
            if (eo[d] !== 1'b0 || ev[d] !== 1'b0) begin
                errors++;
                $display("FAIL reset errors dut%0d: got oob=%b overlap=%b expected 0 0", d, eo[d], ev[d]);
            end
        end
        reset = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_preload_read();
        logic [7:0][63:0] addr;
        logic [7:0][7:0]  g;
        for (int i = 0; i < 8; i++) load_byte(64'h100 + 64'(i), 8'(i + 1));
        for (int i = 0; i < 8; i++) addr[i] = 64'h100 + 64'(i);
        do_burst("preload_read", 8'hFF, 1'b1, addr, '0, 1'b0, 64'h0, 8'h0, g);
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (g[i] !== 8'(i + 1)) begin
                errors++;
                $display("FAIL preload_value lane%0d: got %h expected %h", i, g[i], 8'(i + 1));
            end
        end
    endtask

    task automatic test_write_read();
        logic [7:0][63:0] addr;
        logic [7:0][7:0]  wd;
        logic [7:0][7:0]  g;
        for (int i = 0; i < 8; i++) begin
            addr[i] = 64'h200 + 64'(i);
            wd[i]   = 8'hA0 + 8'(i);
        end
        do_burst("write", 8'hFF, 1'b0, addr, wd, 1'b0, 64'h0, 8'h0, g);
        do_burst("readback", 8'hFF, 1'b1, addr, '0, 1'b0, 64'h0, 8'h0, g);
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (g[i] !== 8'hA0 + 8'(i)) begin
                errors++;
                $display("FAIL readback_value lane%0d: got %h expected %h", i, g[i], 8'hA0 + 8'(i));
            end
        end
    endtask

    task automatic test_random();
        logic [7:0][63:0] addr;
        logic [7:0][7:0]  wd;
        logic [7:0][7:0]  g;
        logic [7:0]       en;
        logic             rw;
        for (int j = 0; j < 16; j++) load_byte(64'h500 + 64'(j), 8'($urandom_range(0, 255)));
        for (int n = 0; n < 12; n++) begin
            en = 8'($urandom_range(1, 255));
            rw = 1'($urandom_range(0, 1));
            for (int i = 0; i < 8; i++) begin
                if ($urandom_range(0, 7) == 0) addr[i] = 64'(DEPTH) + 64'($urandom_range(0, 1000));
                else addr[i] = 64'h500 + 64'($urandom_range(0, 15));
                wd[i] = 8'($urandom_range(0, 255));
            end
            do_burst("random", en, rw, addr, wd, 1'b0, 64'h0, 8'h0, g);
        end
    endtask

    task automatic test_fetch_flow();
        logic [7:0]       vals [16];
        logic [7:0][63:0] addr;
        logic [7:0][7:0]  g1;
        logic [7:0][7:0]  g2;
        logic [127:0]     got_entry;
        logic [127:0]     exp_entry;
        for (int j = 0; j < 16; j++) begin
            vals[j] = (j == 0) ? 8'h01 : 8'($urandom_range(0, 255));
            load_byte(64'h300 + 64'(j), vals[j]);
        end
        for (int i = 0; i < 8; i++) addr[i] = 64'h300 + 64'(i);
        do_burst("fetch_obj", 8'hFF, 1'b1, addr, '0, 1'b0, 64'h0, 8'h0, g1);
        g2 = '0;
        checks++;
        if (g1[0][0] !== 1'b1) begin
            errors++;
            $display("FAIL fetch_nested_bit: got %b expected 1", g1[0][0]);
        end else begin
            for (int i = 0; i < 8; i++) addr[i] = 64'h308 + 64'(i);
            do_burst("fetch_ptr", 8'hFF, 1'b1, addr, '0, 1'b0, 64'h0, 8'h0, g2);
        end
        for (int j = 0; j < 8; j++) begin
            got_entry[127 - 8*j -: 8]      = g1[j];
            got_entry[127 - 8*(j+8) -: 8]  = g2[j];
        end
        for (int j = 0; j < 16; j++) exp_entry[127 - 8*j -: 8] = vals[j];
        checks++;
        if (got_entry !== exp_entry) begin
            errors++;
            $display("FAIL fetch_entry: got %h expected %h", got_entry, exp_entry);
        end
    endtask

    task automatic test_overlap();
        logic [7:0][7:0] exp_d;
        logic [7:0]      exp_v;
        int              a;
        int              pulses3;
        for (int i = 0; i < 8; i++) exp_d[i] = exp_mem[12'h100 + 12'(i)];
        @(negedge clk);
        dram_en = 8'hFF; dram_rdwr = 1'b1;
        for (int i = 0; i < 8; i++) dram_addr[i] = 64'h100 + 64'(i);
        @(posedge clk); #1;
        a = cyc;
        dram_en = '0;
        pulses3 = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            // second strobe on lane 3, taken by the edge two cycles after accept
            dram_en = (cyc == a + 1) ? 8'h08 : 8'h00;
            exp_v = (cyc == a + 3) ? 8'hFF : 8'h00;
            checks++;
            if (dv[0] !== exp_v) begin
                errors++;
                $display("FAIL overlap valid cyc+%0d: got %h expected %h", cyc - a, dv[0], exp_v);
            end
            if (dv[0][3] === 1'b1) pulses3++;
            if (exp_v != 8'h00) begin
                checks++;
                if (dd[0] !== exp_d) begin
                    errors++;
                    $display("FAIL overlap data: got %h expected %h", dd[0], exp_d);
                end
            end
        end
        dram_en = '0;
        checks++;
        if (pulses3 != 1) begin
            errors++;
            $display("FAIL overlap lane3_pulses: got %0d expected 1", pulses3);
        end
        checks++;
        if (ev[0] !== 1'b1) begin
            errors++;
            $display("FAIL overlap err_overlap: got %b expected 1", ev[0]);
        end
    endtask

    task automatic test_oob_conflict();
        logic [7:0][63:0] addr;
        logic [7:0][7:0]  wd;
        logic [7:0][7:0]  g;
        addr = '0; wd = '0;
        addr[0] = 64'(DEPTH) + 64'd5;
        do_burst("oob_read", 8'h01, 1'b1, addr, wd, 1'b0, 64'h0, 8'h0, g);
        checks++;
        if (g[0] !== 8'h00) begin
            errors++;
            $display("FAIL oob_data: got %h expected 00", g[0]);
        end
        addr[2] = 64'h40; addr[5] = 64'h40;
        wd[2] = 8'h22; wd[5] = 8'h55;
        do_burst("conflict_write", 8'h24, 1'b0, addr, wd, 1'b1, 64'h40, 8'h77, g);
        addr[0] = 64'h40;
        do_burst("conflict_read", 8'h01, 1'b1, addr, '0, 1'b0, 64'h0, 8'h0, g);
        checks++;
        if (g[0] !== 8'h55) begin
            errors++;
            $display("FAIL conflict_winner: got %h expected 55", g[0]);
        end
    endtask

    task automatic test_reset_mid();
        logic [7:0][63:0] addr;
        logic [7:0][7:0]  g;
        for (int i = 0; i < 8; i++) addr[i] = 64'h100 + 64'(i);
        @(negedge clk);
        dram_en = 8'hFF; dram_rdwr = 1'b1; dram_addr = addr;
        @(posedge clk); #1;
        dram_en = '0;
        repeat (2) @(posedge clk);
        #2;
        reset = 1'b0;
        exp_oob = 1'b0;
        #1;
        for (int d = 0; d < NDUT; d++) begin
            checks++;
            if (lb[d] !== 8'h00 || dv[d] !== 8'h00) begin
                errors++;
                $display("FAIL reset_mid immediate dut%0d: got busy=%h valid=%h expected 00 00", d, lb[d], dv[d]);
            end
        end
        repeat (2) @(negedge clk);
        reset = 1'b1;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            for (int d = 0; d < NDUT; d++) begin
                checks++;
                if (dv[d] !== 8'h00) begin
                    errors++;
                    $display("FAIL reset_mid stray_valid dut%0d: got %h expected 00", d, dv[d]);
                end
            end
        end
        for (int d = 0; d < NDUT; d++) begin
            checks++;
            if (eo[d] !== 1'b0 || ev[d] !== 1'b0) begin
                errors++;
                $display("FAIL reset_mid errors dut%0d: got oob=%b overlap=%b expected 0 0", d, eo[d], ev[d]);
            end
        end
        do_burst("reset_mid_intact", 8'hFF, 1'b1, addr, '0, 1'b0, 64'h0, 8'h0, g);
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (g[i] !== 8'(i + 1)) begin
                errors++;
                $display("FAIL reset_mid_value lane%0d: got %h expected %h", i, g[i], 8'(i + 1));
            end
        end
        load_byte(64'(DEPTH) + 64'd9, 8'h11);
        @(negedge clk);
        for (int d = 0; d < NDUT; d++) begin
            checks++;
            if (eo[d] !== 1'b1) begin
                errors++;
                $display("FAIL load_oob dut%0d: got %b expected 1", d, eo[d]);
            end
        end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        cyc    = 0;
        test_reset();
        test_preload_read();
        test_write_read();
        test_random();
        test_fetch_flow();
        test_overlap();
        test_oob_conflict();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
